video_frame_arbiter: RTL and testbench
======================================

// Module: video_frame_arbiter
// PURPOSE
//  Shares the HDMI output path (pixel bus into the DVI encoder) among NUM_SRC pixel sources.
//  - Generates 720p timing.
//  - Grants the output to one requester per frame.
//  - Muxes the owner's RGB with aligned hs/vs/de.
//  - Ownership changes only at frame boundaries, so the encoder never sees a torn frame.
//  - Sits between the video sources (colour bar, frame buffers) and dvi_encoder, in the pixel clock domain.
// PARAMETERS
//  NUM_SRC   4     number of requesting sources (2..8)
//  H_ACTIVE  1280  active pixels per line
//  H_FP      110   horizontal front porch (clocks)
//  H_SYNC    40    hsync width (clocks)
//  H_BP      220   horizontal back porch (clocks)
//  V_ACTIVE  720   active lines
//  V_FP      5     vertical front porch (lines)
//  V_SYNC    5     vsync width (lines)
//  V_BP      20    vertical back porch (lines)
//  HS_POL    1     hsync active level
//  VS_POL    1     vsync active level
// PORTS
//  sys_clk      in   1          pixel clock (driven by video_clk at integration)
//  rst_n        in   1          async active-low reset
//  src_req      in   NUM_SRC    per-source request, level
//  src_rgb      in   NUM_SRC*24 per-source {r,g,b}; source i in bits [24i+:24]
//  src_grant    out  NUM_SRC    one-hot owner, constant for a whole frame; 0 = idle
//  pix_x        out  12         active x coordinate (valid when pix_act=1)
//  pix_y        out  12         active y coordinate (valid when pix_act=1)
//  pix_act      out  1          active-region strobe to sources
//  frame_start  out  1          1-clk pulse at h=0,v=0 (first cycle of a new frame's grant)
//  owner_idx    out  3          index of current owner (valid when owner_vld)
//  owner_vld    out  1          a source owns the current frame
//  hs, vs, de   out  1 each     timing to encoder, aligned with rgb
//  rgb_r/g/b    out  8 each     muxed pixel
// BEHAVIOUR
//  Reset values
//   - counters = 0; src_grant = 0; owner_vld = 0; owner_idx = 0.
//   - pix_act = 0; frame_start = 0; de = 0; rgb = 0.
//   - hs = ~HS_POL; vs = ~VS_POL.
//  Timing
//   - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 1650).
//   - v_cnt advances when h_cnt wraps, over 0..V_TOTAL-1 (750).
//   - Active region: h < H_ACTIVE and v < V_ACTIVE.
//   - Sync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (vertical analogous).
//  Latency
//   - Cycle t: pix_x/pix_y/pix_act registered.
//   - Cycle t+1: sources present src_rgb (1-clk source latency is mandatory).
//   - Cycle t+2: hs/vs/de/rgb registered out.
//   - hs/vs/de go through a 2-stage delay so they align with rgb.
//  Arbitration FSM (IDLE, OWN); evaluated only on the last clock of a frame
//   (h = H_TOTAL-1, v = V_TOTAL-1); the new grant takes effect at h = 0, v = 0:
//   - Round-robin: search starts at owner_idx+1 (from IDLE: last owner+1, 0 after reset).
//     The first asserted src_req wins -> OWN.
//   - The current owner with req still high is chosen only if no other req is high.
//   - No req asserted -> IDLE (src_grant = 0, owner_vld = 0).
//  Mid-frame rules
//   - src_req changes never alter src_grant before the frame boundary.
//   - An owner that drops req keeps its grant until the frame ends.
//   - A req rising and falling within one frame is never seen.
//  Output pixel
//   - rgb = owner's src_rgb when de = 1 and OWN.
//   - rgb = 0 in blanking.
//   - In IDLE, rgb is per the CONFIGURATION block.
//  Reset mid-frame: all state to reset values; on release, timing restarts at h = 0, v = 0.
//   - frame_start pulses on the first clock after release.
//   - The first arbitration happens at the end of that first frame.
// CONFIGURATION
//  ARB_IDLE_PATTERN_EN
//   - defined: IDLE active pixels carry 8 vertical bars, each H_ACTIVE/8 wide.
//     Colours: white, yellow, cyan, green, magenta, red, blue, black (full-scale 0xFF/0x00).
//   - undefined: IDLE active pixels = 0 (black).
//   - Timing is identical in both cases.
// STRUCTURE
//  Package video_arb_pkg
//   - H_/V_ default constants and H_TOTAL/V_TOTAL functions.
//   - arb_state_t enum {IDLE, OWN}.
//   - rgb_t struct {r,g,b}.
//  Sub-module video_timing_gen: h/v counters, pix_x/y/act, raw hs/vs/de, frame-end strobe.
//  This module: RR arbiter FSM, 2-stage sync alignment, output mux.
// TESTING
//  1. Reset release, no req: hs period 1650 clks, vs period 750 lines, de high 1280 clks x 720 lines;
//     rgb=0; src_grant=0.
//  2. src_req=4'b0100 mid-frame 0: grant stays 0 until frame 1 start, then 4'b0100, owner_idx=2;
//     rgb equals src_rgb[2] exactly 2 clks after pix_x/pix_y (source drives x-dependent ramp).
//  3. req=4'b1111 held: grants rotate 0001,0010,0100,1000,0001 on consecutive frames;
//     never changes inside a frame.
//  4. Owner 1 drops req at v=300: grant 4'b0010 held to frame end, then 0 if no other req,
//     or next requester (e.g. req=1000 -> 4'b1000).
//  5. rst_n low at h=500,v=400 for 3 clks: outputs go to reset values asynchronously;
//     frame_start pulses one clk after release; grant=0 for that first frame.
//  6. With ARB_IDLE_PATTERN_EN, IDLE: pixel x=0 -> FFFFFF, x=160 -> FFFF00, x=1279 -> 000000;
//     without the macro, all active pixels -> 000000.

Source files
------------

// File: rtl/video_arb_pkg.sv
// Shared constants, types and helpers for the frame arbiter. The optional
// IDLE colour-bar pattern (ARB_IDLE_PATTERN_EN) uses bar_colour().
package video_arb_pkg;

   localparam int unsigned H_ACTIVE_DEF = 1280;
   localparam int unsigned H_FP_DEF     = 110;
   localparam int unsigned H_SYNC_DEF   = 40;
   localparam int unsigned H_BP_DEF     = 220;
   localparam int unsigned V_ACTIVE_DEF = 720;
   localparam int unsigned V_FP_DEF     = 5;
   localparam int unsigned V_SYNC_DEF   = 5;
   localparam int unsigned V_BP_DEF     = 20;

   typedef enum logic [0:0] {IDLE, OWN} arb_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic int unsigned h_total(int unsigned act, int unsigned fp,
                                           int unsigned sync, int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(int unsigned act, int unsigned fp,
                                           int unsigned sync, int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   // Bar order white..black maps onto inverted index bits: g=~b2, r=~b1, b=~b0.
   function automatic rgb_t bar_colour(logic [2:0] bar);
      rgb_t c;
      c.r = {8{~bar[1]}};
      c.g = {8{~bar[2]}};
      c.b = {8{~bar[0]}};
      return c;
   endfunction

endpackage

// File: rtl/video_frame_arbiter_if.sv
// Source-side and encoder-side signals of the frame arbiter; master = arbiter.
interface video_frame_arbiter_if #(
   parameter int unsigned NUM_SRC = 4
);
   logic [NUM_SRC-1:0]    src_req;
   logic [NUM_SRC*24-1:0] src_rgb;
   logic [NUM_SRC-1:0]    src_grant;
   logic [11:0]           pix_x;
   logic [11:0]           pix_y;
   logic                  pix_act;
   logic                  frame_start;
   logic [2:0]            owner_idx;
   logic                  owner_vld;
   logic                  hs;
   logic                  vs;
   logic                  de;
   logic [7:0]            rgb_r;
   logic [7:0]            rgb_g;
   logic [7:0]            rgb_b;

   modport master (
      input  src_req, src_rgb,
      output src_grant, pix_x, pix_y, pix_act, frame_start, owner_idx, owner_vld,
             hs, vs, de, rgb_r, rgb_g, rgb_b
   );

   modport slave (
      output src_req, src_rgb,
      input  src_grant, pix_x, pix_y, pix_act, frame_start, owner_idx, owner_vld,
             hs, vs, de, rgb_r, rgb_g, rgb_b
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster counters plus registered coordinates, raw sync/de and frame strobes.
// All outputs describe the same pixel: the one the counters held one clock earlier.
module video_timing_gen
   import video_arb_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic        pix_act,
   output logic        frame_start,
   output logic        frame_end,
   output logic        hs_raw,
   output logic        vs_raw,
   output logic        de_raw
);

   localparam logic [11:0] H_LAST = 12'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [11:0] V_LAST = 12'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);

   logic [11:0] h_q, h_d, v_q, v_d;
   logic        h_wrap, act, in_hs, in_vs;

   always_comb begin
      h_wrap = (h_q == H_LAST);
      h_d    = h_wrap ? 12'd0 : h_q + 12'd1;
      v_d    = v_q;
      if (h_wrap) v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      act    = (h_q < H_ACT) && (v_q < V_ACT);
      in_hs  = (h_q >= H_SS) && (h_q < H_SE);
      in_vs  = (v_q >= V_SS) && (v_q < V_SE);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q         <= '0;
         v_q         <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_act     <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         hs_raw      <= ~HS_POL;
         vs_raw      <= ~VS_POL;
         de_raw      <= 1'b0;
      end else begin
         h_q         <= h_d;
         v_q         <= v_d;
         pix_x       <= h_q;
         pix_y       <= v_q;
         pix_act     <= act;
         frame_start <= (h_q == 12'd0) && (v_q == 12'd0);
         frame_end   <= h_wrap && (v_q == V_LAST);
         hs_raw      <= in_hs ? HS_POL : ~HS_POL;
         vs_raw      <= in_vs ? VS_POL : ~VS_POL;
         de_raw      <= act;
      end
   end

endmodule

// File: rtl/video_frame_arbiter.sv
// Per-frame round-robin owner of the pixel path, sync alignment and RGB mux.
// Define ARB_IDLE_PATTERN_EN to show colour bars while no source owns the frame.
module video_frame_arbiter
   import video_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC  = 4,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input logic                   sys_clk,
   input logic                   rst_n,
   video_frame_arbiter_if.master bus
);

   localparam int NSRC = int'(NUM_SRC);

   logic       frame_end, hs_raw, vs_raw, de_raw;
   logic       hs_d1, vs_d1, de_d1, hs_q, vs_q, de_q;
   arb_state_t state_q, state_d;
   logic [2:0] owner_q, owner_d, ptr_q, ptr_d;
   logic [NUM_SRC-1:0] req_rot;
   logic       found;
   int         win;
   rgb_t       sel_rgb, idle_rgb, nxt_rgb, rgb_q;

   video_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) u_timing (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .pix_x      (bus.pix_x),
      .pix_y      (bus.pix_y),
      .pix_act    (bus.pix_act),
      .frame_start(bus.frame_start),
      .frame_end  (frame_end),
      .hs_raw     (hs_raw),
      .vs_raw     (vs_raw),
      .de_raw     (de_raw)
   );

   // Requests rotated so bit 0 is the first candidate after the previous owner;
   // the previous owner itself therefore lands last.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      found   = 1'b0;
      win     = 0;
      req_rot = NUM_SRC'({bus.src_req, bus.src_req} >> ptr_q);
      for (int k = 0; k < NSRC; k++) begin
         if (!found && req_rot[k]) begin
            found = 1'b1;
            win   = int'(ptr_q) + k;
         end
      end
      if (win >= NSRC) win = win - NSRC;
      if (frame_end) begin
         if (found) begin
            state_d = OWN;
            owner_d = 3'(win);
            ptr_d   = (win == NSRC - 1) ? 3'd0 : 3'(win + 1);
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         bus.src_grant[i] = (state_q == OWN) && (owner_q == 3'(i));
      end
   end

   assign bus.owner_idx = owner_q;
   assign bus.owner_vld = (state_q == OWN);

`ifdef ARB_IDLE_PATTERN_EN
   localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   logic [11:0] x_d1, bar_idx;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) x_d1 <= '0;
      else        x_d1 <= bus.pix_x;
   end

   always_comb begin
      bar_idx  = x_d1 / 12'(BAR_W);
      idle_rgb = bar_colour((bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0]);
   end
`else
   assign idle_rgb = '0;
`endif

   always_comb begin
      sel_rgb = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (owner_q == 3'(i)) sel_rgb = bus.src_rgb[24*i +: 24];
      end
      nxt_rgb = '0;
      if (de_d1) nxt_rgb = (state_q == OWN) ? sel_rgb : idle_rgb;
   end

   // Sources answer one clock after pix_x/pix_y, so sync/de take two stages.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_d1 <= ~HS_POL;
         vs_d1 <= ~VS_POL;
         de_d1 <= 1'b0;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         de_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         hs_d1 <= hs_raw;
         vs_d1 <= vs_raw;
         de_d1 <= de_raw;
         hs_q  <= hs_d1;
         vs_q  <= vs_d1;
         de_q  <= de_d1;
         rgb_q <= nxt_rgb;
      end
   end

   assign bus.hs    = hs_q;
   assign bus.vs    = vs_q;
   assign bus.de    = de_q;
   assign bus.rgb_r = rgb_q.r;
   assign bus.rgb_g = rgb_q.g;
   assign bus.rgb_b = rgb_q.b;

endmodule

// File: tb/tb_video_frame_arbiter.sv
// Randomised bench for video_frame_arbiter on a shrunken raster, checked every
// clock against a frame-level model of position, ownership and pixel data.
module tb_video_frame_arbiter;

   localparam int N     = 4;
   localparam int HA    = 16;
   localparam int HFP   = 2;
   localparam int HSY   = 3;
   localparam int HBP   = 3;
   localparam int VA    = 6;
   localparam int VFP   = 1;
   localparam int VSY   = 2;
   localparam int VBP   = 1;
   localparam int HT    = HA + HFP + HSY + HBP;
   localparam int VT    = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam bit HS_POL = 1'b1;
   localparam bit VS_POL = 1'b0;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b1;
   always #5 sys_clk = ~sys_clk;

   video_frame_arbiter_if #(.NUM_SRC(N)) bus ();

   video_frame_arbiter #(
      .NUM_SRC(N),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: clocks since reset release and the owner of the current frame.
   int          k;
   bit          m_vld;
   int          m_owner;
   int          m_next;
   logic [11:0] prev_x, prev_y;
   logic [7:0]  salt [N];

   function automatic logic [23:0] src_pix(int i, logic [11:0] x, logic [11:0] y);
      return {8'(x * 5 + 12'(i * 37)), 8'(y * 11 + 12'(i * 3)), salt[i] ^ x[7:0]};
   endfunction

   function automatic logic [23:0] idle_exp(int x);
`ifdef ARB_IDLE_PATTERN_EN
      logic [23:0] bars [8];
      int b;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      b = x / (HA / 8);
      if (b > 7) b = 7;
      return bars[b];
`else
      return (x < 0) ? 24'h1 : 24'h0;
`endif
   endfunction

   task automatic model_reset();
      k       = 0;
      m_vld   = 1'b0;
      m_owner = 0;
      m_next  = 0;
      prev_x  = '0;
      prev_y  = '0;
   endtask

   // Round robin: first requester at or after the slot following the last owner.
   task automatic model_arb();
      int w;
      w = -1;
      for (int j = 0; j < N; j++) begin
         if (w < 0 && bus.src_req[(m_next + j) % N]) w = (m_next + j) % N;
      end
      if (w >= 0) begin
         m_vld   = 1'b1;
         m_owner = w;
         m_next  = (w + 1) % N;
      end else begin
         m_vld = 1'b0;
      end
   endtask

   task automatic step();
      int p, x, y, q, qx, qy;
      bit e_act, e_hs, e_vs, e_de;
      logic [23:0] e_rgb;
      logic [N*24-1:0] rgbs;
      logic [3:0] e_grant;
      logic [2:0] e_idx;
      @(posedge sys_clk);
      #1;
      k++;
      if (k >= 2 && (k - 2) % FRAME == FRAME - 1) model_arb();
      p = (k - 1) % FRAME;
      x = p % HT;
      y = p / HT;
      e_act = (x < HA) && (y < VA);
      check_eq("pix", {bus.pix_act, bus.frame_start,
                       bus.pix_act ? bus.pix_y : 12'd0, bus.pix_act ? bus.pix_x : 12'd0},
               {e_act, p == 0, e_act ? 12'(y) : 12'd0, e_act ? 12'(x) : 12'd0});
      if (k < 3) begin
         e_hs  = ~HS_POL;
         e_vs  = ~VS_POL;
         e_de  = 1'b0;
         e_rgb = '0;
      end else begin
         q     = (k - 3) % FRAME;
         qx    = q % HT;
         qy    = q / HT;
         e_de  = (qx < HA) && (qy < VA);
         e_hs  = (qx >= HA + HFP && qx < HA + HFP + HSY) ? HS_POL : ~HS_POL;
         e_vs  = (qy >= VA + VFP && qy < VA + VFP + VSY) ? VS_POL : ~VS_POL;
         e_rgb = !e_de ? 24'h0 : m_vld ? src_pix(m_owner, 12'(qx), 12'(qy)) : idle_exp(qx);
      end
      check_eq("out", {bus.hs, bus.vs, bus.de, bus.rgb_r, bus.rgb_g, bus.rgb_b},
               {e_hs, e_vs, e_de, e_rgb});
      e_grant = m_vld ? 4'(1 << m_owner) : 4'd0;
      e_idx   = m_vld ? 3'(m_owner) : 3'd0;
      check_eq("arb", {bus.owner_vld, bus.owner_vld ? bus.owner_idx : 3'd0, bus.src_grant},
               {m_vld, e_idx, e_grant});
      @(negedge sys_clk);
      for (int i = 0; i < N; i++) rgbs[24*i +: 24] = src_pix(i, prev_x, prev_y);
      bus.src_rgb = rgbs;
      prev_x = bus.pix_x;
      prev_y = bus.pix_y;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to_line(input int v);
      int guard;
      guard = 0;
      do begin
         step();
         guard++;
      end while (((k - 1) % FRAME) != v * HT && guard <= FRAME);
   endtask

   task automatic do_reset(input int hold);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_pix", {bus.pix_act, bus.frame_start, bus.pix_x, bus.pix_y}, 64'd0);
      check_eq("rst_out", {bus.hs, bus.vs, bus.de, bus.rgb_r, bus.rgb_g, bus.rgb_b},
               {~HS_POL, ~VS_POL, 1'b0, 24'h0});
      check_eq("rst_arb", {bus.owner_vld, bus.owner_idx, bus.src_grant}, 64'd0);
      repeat (hold) @(negedge sys_clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      bus.src_req = '0;
      bus.src_rgb = '0;
      for (int i = 0; i < N; i++) salt[i] = 8'($urandom);
      model_reset();
      do_reset(3);

      run(2 * FRAME);                  // idle raster

      run_to_line(2);                  // single requester arriving mid-frame
      bus.src_req = 4'b0100;
      run(2 * FRAME);

      bus.src_req = 4'b1111;           // full rotation
      run(5 * FRAME);

      bus.src_req = 4'b0010;           // owner 1 drops mid-frame, then hand-over
      run_to_line(3);
      run_to_line(3);
      bus.src_req = 4'b0000;
      run_to_line(3);
      run_to_line(3);
      bus.src_req = 4'b0010;
      run_to_line(3);
      run_to_line(3);
      bus.src_req = 4'b1000;
      run_to_line(3);
      run_to_line(3);

      for (int f = 0; f < 16; f++) begin
         run_to_line(int'($urandom_range(0, 3)));
         bus.src_req = 4'($urandom);
         run(int'($urandom_range(1, 20)));
         bus.src_req = 4'($urandom);
         run_to_line(VA + 1);
         if ($urandom_range(0, 3) == 0) bus.src_req = 4'($urandom);
      end

      bus.src_req = 4'b1111;
      run_to_line(4);
      run(int'($urandom_range(1, HT - 1)));
      do_reset(3);                     // asynchronous reset mid-frame
      bus.src_req = 4'b0110;
      run(3 * FRAME);
      bus.src_req = 4'($urandom);
      run(2 * FRAME);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
